ws2812_chain: RTL and testbench

Parametrised WS2812 string driver, successor to the single-word ws2812 core.
- Holds a frame buffer of NUM_LEDS 24-bit colours written over a simple write port.
- Serialises the whole chain in GRB order with configurable bit timing, then emits the latch (reset) gap.
- Adds frame-on-demand or continuous auto-refresh and a 3-bit global dimming shift.
- Sits behind the harness wishbone/IO mux like the other project blocks; one serial output pin.

---
 rtl/ws2812_pkg.sv | 31 +++
 rtl/ws2812_chain_if.sv | 26 ++
 rtl/ws2812_bit_timer.sv | 50 +++++
 rtl/ws2812_chain.sv | 144 ++++++++++++++
 tb/tb_ws2812_chain.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, default timing and colour helper for the WS2812 chain driver.
// Contents:
//   state_e         - frame FSM states (idle, sending bits, latch gap)
//   Def*            - default bit/latch timing at a 12 MHz clock
//   rgb_to_grb_dim  - reorder an RGB word into wire order and apply the dim shift
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StLatch
    } state_e;

    localparam int unsigned DefTBit   = 15;   // 1.25 us per bit
    localparam int unsigned DefT0H    = 4;
    localparam int unsigned DefT1H    = 8;
    localparam int unsigned DefTReset = 720;  // 60 us latch gap

    // LEDs expect green first; every channel is right-shifted by dim.
    function automatic logic [23:0] rgb_to_grb_dim(input logic [23:0] rgb,
                                                   input logic [2:0]  dim);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = rgb[23:16] >> dim;
        g = rgb[15:8] >> dim;
        b = rgb[7:0] >> dim;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_chain_if.sv
// Host-side signal bundle of the WS2812 chain driver.
//   master: rgb_data/led_num/write (buffer write), refresh, auto_mode, dim -> driver
//   slave : busy, frame_done, data (serial line) <- driver
interface ws2812_chain_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [23:0]       rgb_data;
    logic [ADDR_W-1:0] led_num;
    logic              write;
    logic              refresh;
    logic              auto_mode;
    logic [2:0]        dim;
    logic              busy;
    logic              frame_done;
    logic              data;

    modport master (
        output rgb_data, led_num, write, refresh, auto_mode, dim,
        input  busy, frame_done, data
    );

    modport slave (
        input  rgb_data, led_num, write, refresh, auto_mode, dim,
        output busy, frame_done, data
    );
endinterface

// File: rtl/ws2812_bit_timer.sv
// Per-bit timing for the WS2812 serial line.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   en_i          - FSM is in the send state this cycle
//   send_next_i   - FSM will be in the send state next cycle
//   bit_next_i    - value of the bit being sent next cycle
//   bit_end_o     - this is the last cycle of the current bit slot
//   data_o        - registered serial output
module ws2812_bit_timer #(
    parameter int unsigned T_BIT = 15,
    parameter int unsigned T0H   = 4,
    parameter int unsigned T1H   = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic send_next_i,
    input  logic bit_next_i,
    output logic bit_end_o,
    output logic data_o
);
    localparam int unsigned CntW = (T_BIT > 1) ? $clog2(T_BIT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            data_q, data_d;

    assign bit_end_o = en_i && (cnt_q == CntW'(T_BIT - 1));

    // The line is registered, so the high/low decision is made from next-cycle
    // count and bit value; this gives the one-cycle start latency.
    always_comb begin
        cnt_d = '0;
        if (en_i && send_next_i && !bit_end_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        data_d = send_next_i && (cnt_d < (bit_next_i ? CntW'(T1H) : CntW'(T0H)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            data_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/ws2812_chain.sv
// WS2812 string driver: frame buffer of NUM_LEDS colours, GRB serialisation with
// global dimming, latch gap, refresh-on-demand (one-deep pending) or auto-refresh.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - buffer write port, refresh/auto_mode/dim controls,
//                  busy/frame_done status and the registered serial line
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned T_BIT    = DefTBit,
    parameter int unsigned T0H      = DefT0H,
    parameter int unsigned T1H      = DefT1H,
    parameter int unsigned T_RESET  = DefTReset
) (
    input  logic          clk,
    input  logic          reset_n,
    ws2812_chain_if.slave bus
);
    localparam int unsigned LedW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned RstW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

    state_e      state_q, state_d;
    logic [23:0] buf_q [NUM_LEDS];
    logic [LedW-1:0] led_q, led_d, led_next;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [23:0] shift_q, shift_d;
    logic [2:0]  dim_q, dim_d;
    logic        pending_q, pending_d;
    logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
    logic        start_frame;
    logic        bit_end;
    logic        wr_en;
    logic        last_led;
    logic        gap_end;

    assign wr_en    = bus.write && ({1'b0, bus.led_num} < (ADDR_W + 1)'(NUM_LEDS));
    assign last_led = (led_q == LedW'(NUM_LEDS - 1));
    assign gap_end  = (rst_cnt_q == RstW'(T_RESET - 1));

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        dim_d       = dim_q;
        rst_cnt_d   = '0;
        start_frame = 1'b0;
        // Guarded so the buffer is never indexed past the last LED.
        led_next    = last_led ? '0 : led_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (bus.refresh || bus.auto_mode || pending_q) begin
                    start_frame = 1'b1;
                end
            end
            StSend: begin
                if (bit_end) begin
                    if (bit_idx_q == 5'd0) begin
                        if (last_led) begin
                            state_d = StLatch;
                        end else begin
                            // Next word loads at the slot boundary: no gap cycle.
                            led_d     = led_next;
                            bit_idx_d = 5'd23;
                            shift_d   = rgb_to_grb_dim(buf_q[led_next], dim_q);
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                    end
                end
            end
            StLatch: begin
                if (gap_end) begin
                    if (bus.auto_mode || pending_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_frame) begin
            state_d   = StSend;
            led_d     = '0;
            bit_idx_d = 5'd23;
            dim_d     = bus.dim;
            shift_d   = rgb_to_grb_dim(buf_q[0], bus.dim);
        end

        // Refresh while busy collapses into a single pending frame.
        pending_d = start_frame ? 1'b0 : (pending_q || (bus.refresh && state_q != StIdle));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            led_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dim_q     <= '0;
            pending_q <= 1'b0;
            rst_cnt_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            dim_q     <= dim_d;
            pending_q <= pending_d;
            rst_cnt_q <= rst_cnt_d;
            if (wr_en) begin
                buf_q[bus.led_num[LedW-1:0]] <= bus.rgb_data;
            end
        end
    end

    ws2812_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (state_q == StSend),
        .send_next_i (state_d == StSend),
        .bit_next_i  (shift_d[23]),
        .bit_end_o   (bit_end),
        .data_o      (bus.data)
    );

    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = (state_q == StLatch) && gap_end;
endmodule

// File: tb/tb_ws2812_chain.sv
// Scoreboard bench for ws2812_chain: expected per-bit high times are queued when a
// frame is requested and popped as each 15-cycle bit slot is observed on the line.
module tb_ws2812_chain;
    localparam int NUM_LEDS = 8;
    localparam int T_BIT    = 15;
    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int T_RESET  = 720;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    ws2812_chain_if #(.ADDR_W(8)) bus ();

    ws2812_chain #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (8),
        .T_BIT    (T_BIT),
        .T0H      (T0H),
        .T1H      (T1H),
        .T_RESET  (T_RESET)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    logic [23:0] mdl [NUM_LEDS];

    task automatic wr(input int idx, input logic [23:0] val);
        @(posedge clk);
        #1;
        bus.write    = 1'b1;
        bus.led_num  = 8'(idx);
        bus.rgb_data = val;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        if (idx < NUM_LEDS) mdl[idx] = val;
    endtask

    // Returns #1 after the triggering edge, i.e. inside the first frame cycle.
    task automatic pulse_refresh();
        @(posedge clk);
        #1;
        bus.refresh = 1'b1;
        @(posedge clk);
        #1;
        bus.refresh = 1'b0;
    endtask

    task automatic push_word(input logic [23:0] grb);
        for (int b = 23; b >= 0; b--) exp_q.push_back(grb[b] ? T1H : T0H);
    endtask

    function automatic logic [23:0] model_grb(input logic [23:0] rgb, input int d);
        logic [7:0] r, g, b;
        r = rgb[23:16] >> d;
        g = rgb[15:8] >> d;
        b = rgb[7:0] >> d;
        return {g, r, b};
    endfunction

    task automatic push_model_leds(input int first, input int last, input int d);
        for (int i = first; i <= last; i++) push_word(model_grb(mdl[i], d));
    endtask

    task automatic check_frame(input string name);
        int busy_low;
        int lat_bad;
        int fd_cnt;
        int fd_pos;
        busy_low = 0;
        lat_bad  = 0;
        fd_cnt   = 0;
        fd_pos   = -1;
        for (int s = 0; s < NUM_LEDS * 24; s++) begin
            logic [T_BIT-1:0] pat;
            logic [T_BIT-1:0] epat;
            int hi;
            pat = '0;
            for (int c = 0; c < T_BIT; c++) begin
                @(negedge clk);
                pat[c] = bus.data;
                if (bus.busy !== 1'b1) busy_low++;
                if (bus.frame_done !== 1'b0) fd_cnt++;
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s slot %0d: no expected bit queued, line showed %b", name, s, pat);
            end else begin
                hi = exp_q.pop_front();
                for (int c = 0; c < T_BIT; c++) epat[c] = (c < hi);
                if (pat !== epat) begin
                    miscompares++;
                    $display("FAIL %s slot %0d: line %b, required %b", name, s, pat, epat);
                end
            end
        end
        for (int c = 0; c < T_RESET; c++) begin
            @(negedge clk);
            if (bus.data !== 1'b0) lat_bad++;
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.frame_done !== 1'b0) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
        vectors++;
        if (busy_low != 0) begin
            miscompares++;
            $display("FAIL %s busy: %0d low cycles inside frame, required 0", name, busy_low);
        end
        vectors++;
        if (lat_bad != 0) begin
            miscompares++;
            $display("FAIL %s latch: %0d high cycles in gap, required 0", name, lat_bad);
        end
        vectors++;
        if (fd_cnt != 1 || fd_pos != T_RESET - 1) begin
            miscompares++;
            $display("FAIL %s frame_done: %0d pulses, last at gap cycle %0d, required 1 at %0d",
                     name, fd_cnt, fd_pos, T_RESET - 1);
        end
    endtask

    task automatic expect_idle(input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.data !== 1'b0 || bus.frame_done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s idle: %0d cycles not idle (busy=%b data=%b), required 0",
                     name, bad, bus.busy, bus.data);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({bus.busy, bus.data, bus.frame_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset outputs: busy/data/frame_done=%b, required 000",
                     {bus.busy, bus.data, bus.frame_done});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        expect_idle("after_reset");
    endtask

    // All-zero buffer: 192 short bits then the gap, 3600 busy cycles.
    task automatic test_blank();
        push_model_leds(0, NUM_LEDS - 1, 0);
        pulse_refresh();
        check_frame("blank");
        expect_idle("blank");
    endtask

    task automatic test_out_of_range();
        wr(8, 24'hFFFFFF);
        for (int i = 0; i < NUM_LEDS; i++) push_word(24'h000000);
        pulse_refresh();
        check_frame("oor");
        expect_idle("oor");
    endtask

    task automatic test_colors();
        wr(0, 24'hFF0000);
        wr(7, 24'h0000FF);
        push_word(24'h00FF00);
        push_model_leds(1, 6, 0);
        push_word(24'h0000FF);
        pulse_refresh();
        check_frame("colors");
        expect_idle("colors");
    endtask

    // dim must be taken at frame start, so it is dropped right after the trigger.
    task automatic test_dim();
        wr(0, 24'h80FF10);
        bus.dim = 3'd3;
        push_word(24'h1F1002);
        push_model_leds(1, NUM_LEDS - 1, 3);
        pulse_refresh();
        bus.dim = 3'd0;
        check_frame("dim");
        expect_idle("dim");
    endtask

    task automatic test_auto();
        push_model_leds(0, NUM_LEDS - 1, 0);
        push_model_leds(0, NUM_LEDS - 1, 0);
        @(posedge clk);
        #1;
        bus.auto_mode = 1'b1;
        @(posedge clk);
        #1;
        check_frame("auto1");
        fork
            begin
                repeat (200) @(posedge clk);
                #1;
                bus.auto_mode = 1'b0;
            end
        join_none
        check_frame("auto2");
        expect_idle("auto");
    endtask

    task automatic test_back_to_back();
        push_model_leds(0, NUM_LEDS - 1, 0);
        push_model_leds(0, NUM_LEDS - 1, 0);
        pulse_refresh();
        fork
            begin
                repeat (50) @(posedge clk);
                pulse_refresh();
                repeat (70) @(posedge clk);
                pulse_refresh();
                repeat (300) @(posedge clk);
                pulse_refresh();
            end
        join_none
        check_frame("pend1");
        check_frame("pend2");
        expect_idle("pend");
    endtask

    task automatic test_reset_mid();
        pulse_refresh();
        @(negedge clk);
        vectors++;
        if (bus.data !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid pre: data=%b, required 1", bus.data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.data !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid async: data=%b busy=%b, required 0 0", bus.data, bus.busy);
        end
        for (int i = 0; i < NUM_LEDS; i++) mdl[i] = 24'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_idle("reset_mid");
        push_model_leds(0, NUM_LEDS - 1, 0);
        pulse_refresh();
        check_frame("reset_restart");
        expect_idle("reset_restart");
    endtask

    initial begin
        bus.write     = 1'b0;
        bus.led_num   = '0;
        bus.rgb_data  = '0;
        bus.refresh   = 1'b0;
        bus.auto_mode = 1'b0;
        bus.dim       = 3'd0;
        for (int i = 0; i < NUM_LEDS; i++) mdl[i] = 24'h0;

        test_reset();
        test_blank();
        test_out_of_range();
        test_colors();
        test_dim();
        test_auto();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
